// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch controller, the PC, instruction memory and the decoder.
// The master side is the fetch controller; the slave side is the surrounding system.
interface inst_fetch_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned IW = 32
);
   logic [AW-1:0] Address;
   logic          incPC;
   logic          loadFromI;
   logic [AW-1:0] I;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_rvalid;
   logic [IW-1:0] mem_rdata;
   logic          inst_valid;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_addr;
   logic          inst_ready;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          halt;

   modport master (
      input  Address, mem_rvalid, mem_rdata, inst_ready, branch_taken, branch_target, halt,
      output incPC, loadFromI, I, mem_req, mem_addr, inst_valid, inst, inst_addr
   );

   modport slave (
      output Address, mem_rvalid, mem_rdata, inst_ready, branch_taken, branch_target, halt,
      input  incPC, loadFromI, I, mem_req, mem_addr, inst_valid, inst, inst_addr
   );
endinterface

// File: rtl/inst_fetch.sv
// Fetch controller: one memory read per PC value, holds the word for the decoder,
// steps the PC with incPC and redirects it with loadFromI on a taken branch.
module inst_fetch #(
   parameter int unsigned INSTMEM_ADDR_WIDTH = 16,
   parameter int unsigned INST_WIDTH         = 32
) (
   input  logic        clk,
   input  logic        reset,
   inst_fetch_if.master bus
);
   localparam int unsigned AW = INSTMEM_ADDR_WIDTH;
   localparam int unsigned IW = INST_WIDTH;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_HOLD  = 3'd2,
      S_REDIR = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t        r_state,       w_state_nxt;
   logic [AW-1:0] r_req_addr,    w_req_addr_nxt;
   logic [AW-1:0] r_I,           w_I_nxt;
   logic [AW-1:0] r_inst_addr,   w_inst_addr_nxt;
   logic [IW-1:0] r_inst,        w_inst_nxt;
   logic          r_incPC,       w_incPC_nxt;
   logic          r_loadFromI,   w_loadFromI_nxt;
   logic          r_inst_valid,  w_inst_valid_nxt;
   logic          w_mem_req;

   assign w_mem_req = (r_state == S_REQ) && !bus.halt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_REQ;
         r_req_addr   <= '0;
         r_I          <= '0;
         r_inst_addr  <= '0;
         r_inst       <= '0;
         r_incPC      <= 1'b0;
         r_loadFromI  <= 1'b0;
         r_inst_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_addr   <= w_req_addr_nxt;
         r_I          <= w_I_nxt;
         r_inst_addr  <= w_inst_addr_nxt;
         r_inst       <= w_inst_nxt;
         r_incPC      <= w_incPC_nxt;
         r_loadFromI  <= w_loadFromI_nxt;
         r_inst_valid <= w_inst_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_req_addr_nxt   = r_req_addr;
      w_I_nxt          = r_I;
      w_inst_addr_nxt  = r_inst_addr;
      w_inst_nxt       = r_inst;
      w_incPC_nxt      = 1'b0;
      w_loadFromI_nxt  = 1'b0;
      w_inst_valid_nxt = r_inst_valid;

      unique case (r_state)
         S_REQ: begin
            if (w_mem_req) begin
               w_req_addr_nxt = bus.Address;
               w_state_nxt    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.mem_rvalid) begin
               w_inst_nxt       = bus.mem_rdata;
               w_inst_addr_nxt  = r_req_addr;
               w_inst_valid_nxt = 1'b1;
               w_incPC_nxt      = 1'b1;
               w_state_nxt      = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_inst_valid && bus.inst_ready) begin
               w_inst_valid_nxt = 1'b0;
               w_state_nxt      = S_REQ;
            end
         end
         S_REDIR: w_state_nxt = S_REQ;
         S_DRAIN: begin
            if (bus.mem_rvalid) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase

      // A redirect overrides everything above; an issued or pending read must be drained first
      if (bus.branch_taken) begin
         w_I_nxt          = bus.branch_target;
         w_loadFromI_nxt  = 1'b1;
         w_incPC_nxt      = 1'b0;
         w_inst_valid_nxt = 1'b0;
         w_inst_nxt       = r_inst;
         w_inst_addr_nxt  = r_inst_addr;
         unique case (r_state)
            S_REQ:   w_state_nxt = w_mem_req      ? S_DRAIN : S_REDIR;
            S_WAIT:  w_state_nxt = bus.mem_rvalid ? S_REDIR : S_DRAIN;
            S_DRAIN: w_state_nxt = bus.mem_rvalid ? S_REDIR : S_DRAIN;
            default: w_state_nxt = S_REDIR;
         endcase
      end
   end

   assign bus.mem_req    = w_mem_req;
   assign bus.mem_addr   = bus.Address;
   assign bus.incPC      = r_incPC;
   assign bus.loadFromI  = r_loadFromI;
   assign bus.I          = r_I;
   assign bus.inst_valid = r_inst_valid;
   assign bus.inst       = r_inst;
   assign bus.inst_addr  = r_inst_addr;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: PC and memory models around the DUT, a per-cycle
// vector table for the basic flow, and hand-written sequences for the multi-cycle corners.
module tb_inst_fetch;
   logic clk   = 1'b0;
   logic reset = 1'b0;

   inst_fetch_if #(.AW(16), .IW(32)) bus ();

   inst_fetch #(.INSTMEM_ADDR_WIDTH(16), .INST_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_excl = 0;

   // PC model
   always @(posedge clk or posedge reset) begin
      if (reset)              bus.Address <= 16'h0;
      else if (bus.loadFromI) bus.Address <= bus.I;
      else if (bus.incPC)     bus.Address <= bus.Address + 16'd1;
   end

   // Memory model: one pending read, data = 0xA0 + address, not cleared by reset
   int          lat    = 1;
   logic        m_pend = 1'b0;
   int          m_cnt  = 0;
   logic [15:0] m_addr = 16'h0;
   always @(posedge clk) begin
      if (bus.mem_req && !reset) begin
         m_pend <= 1'b1;
         m_cnt  <= lat - 1;
         m_addr <= bus.mem_addr;
      end else if (m_pend) begin
         if (m_cnt == 0) m_pend <= 1'b0;
         else            m_cnt  <= m_cnt - 1;
      end
   end
   assign bus.mem_rvalid = m_pend && (m_cnt == 0);
   assign bus.mem_rdata  = 32'h0000_00A0 + {16'h0, m_addr};

   always @(negedge clk) if (reset === 1'b0 && bus.incPC === 1'b1 && bus.loadFromI === 1'b1) n_excl++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic h);
      @(negedge clk);
      reset = 1'b1;
      bus.halt = h;
      bus.branch_taken = 1'b0;
      bus.branch_target = 16'h0;
      bus.inst_ready = 1'b1;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   typedef struct {
      logic        halt, ready, br;
      logic [15:0] tgt;
      logic        mreq;
      logic [15:0] maddr;
      logic        inc, lfi;
      logic [15:0] i;
      logic        iv;
      logic [31:0] inst;
      logic [15:0] iaddr;
   } vec_t;

   function automatic vec_t mk(input logic h, input logic r, input logic b, input logic [15:0] t,
                               input logic mr, input logic [15:0] ma, input logic inc, input logic lf,
                               input logic [15:0] i, input logic iv, input logic [31:0] in,
                               input logic [15:0] ia);
      vec_t v;
      v.halt = h; v.ready = r; v.br = b; v.tgt = t;
      v.mreq = mr; v.maddr = ma; v.inc = inc; v.lfi = lf;
      v.i = i; v.iv = iv; v.inst = in; v.iaddr = ia;
      return v;
   endfunction

   vec_t tbl [20];

   initial begin
      logic [31:0] got_inst [4];
      logic [15:0] got_addr [4];
      logic [15:0] req_a;
      logic [31:0] v0;
      int n, n_inc, lf, early, bad;
      logic found, got_req, rv;

      // halt from reset, fetch at latency 1, branch in HOLD, stall with halt
      for (int k = 0; k < 6; k++)
         tbl[k] = mk(1'b1,1'b1,1'b0,16'h0, 1'b0,16'h0, 1'b0,1'b0,16'h0, 1'b0,32'h0,16'h0);
      tbl[6]  = mk(1'b0,1'b1,1'b0,16'h0,  1'b1,16'h0,  1'b0,1'b0,16'h0,  1'b0,32'h0,  16'h0);
      tbl[7]  = mk(1'b0,1'b1,1'b0,16'h0,  1'b0,16'h0,  1'b0,1'b0,16'h0,  1'b0,32'h0,  16'h0);
      tbl[8]  = mk(1'b0,1'b1,1'b0,16'h0,  1'b0,16'h0,  1'b1,1'b0,16'h0,  1'b1,32'hA0, 16'h0);
      tbl[9]  = mk(1'b0,1'b1,1'b0,16'h0,  1'b1,16'h1,  1'b0,1'b0,16'h0,  1'b0,32'hA0, 16'h0);
      tbl[10] = mk(1'b0,1'b1,1'b0,16'h0,  1'b0,16'h1,  1'b0,1'b0,16'h0,  1'b0,32'hA0, 16'h0);
      tbl[11] = mk(1'b0,1'b1,1'b1,16'h40, 1'b0,16'h1,  1'b1,1'b0,16'h0,  1'b1,32'hA1, 16'h1);
      tbl[12] = mk(1'b0,1'b1,1'b0,16'h0,  1'b0,16'h2,  1'b0,1'b1,16'h40, 1'b0,32'hA1, 16'h1);
      tbl[13] = mk(1'b0,1'b1,1'b0,16'h0,  1'b1,16'h40, 1'b0,1'b0,16'h40, 1'b0,32'hA1, 16'h1);
      tbl[14] = mk(1'b0,1'b1,1'b0,16'h0,  1'b0,16'h40, 1'b0,1'b0,16'h40, 1'b0,32'hA1, 16'h1);
      tbl[15] = mk(1'b0,1'b0,1'b0,16'h0,  1'b0,16'h40, 1'b1,1'b0,16'h40, 1'b1,32'hE0, 16'h40);
      tbl[16] = mk(1'b1,1'b0,1'b0,16'h0,  1'b0,16'h41, 1'b0,1'b0,16'h40, 1'b1,32'hE0, 16'h40);
      tbl[17] = mk(1'b1,1'b1,1'b0,16'h0,  1'b0,16'h41, 1'b0,1'b0,16'h40, 1'b1,32'hE0, 16'h40);
      tbl[18] = mk(1'b1,1'b1,1'b0,16'h0,  1'b0,16'h41, 1'b0,1'b0,16'h40, 1'b0,32'hE0, 16'h40);
      tbl[19] = mk(1'b0,1'b1,1'b0,16'h0,  1'b1,16'h41, 1'b0,1'b0,16'h40, 1'b0,32'hE0, 16'h40);

      bus.halt = 1'b1;
      bus.inst_ready = 1'b1;
      bus.branch_taken = 1'b0;
      bus.branch_target = 16'h0;
      lat = 1;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_incPC",      32'(bus.incPC),      32'h0);
      chk("rst_loadFromI",  32'(bus.loadFromI),  32'h0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("rst_I",          32'(bus.I),          32'h0);
      chk("rst_inst",       bus.inst,            32'h0);
      chk("rst_inst_addr",  32'(bus.inst_addr),  32'h0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) reset = 1'b0;
         bus.halt = tbl[i].halt;
         bus.inst_ready = tbl[i].ready;
         bus.branch_taken = tbl[i].br;
         bus.branch_target = tbl[i].tgt;
         #1;
         chk($sformatf("v%0d_mem_req", i),    32'(bus.mem_req),    32'(tbl[i].mreq));
         chk($sformatf("v%0d_mem_addr", i),   32'(bus.mem_addr),   32'(tbl[i].maddr));
         chk($sformatf("v%0d_incPC", i),      32'(bus.incPC),      32'(tbl[i].inc));
         chk($sformatf("v%0d_loadFromI", i),  32'(bus.loadFromI),  32'(tbl[i].lfi));
         chk($sformatf("v%0d_I", i),          32'(bus.I),          32'(tbl[i].i));
         chk($sformatf("v%0d_inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].iv));
         chk($sformatf("v%0d_inst", i),       bus.inst,            tbl[i].inst);
         chk($sformatf("v%0d_inst_addr", i),  32'(bus.inst_addr),  32'(tbl[i].iaddr));
      end
      bus.branch_taken = 1'b0;

      // Stream four words at latency 3
      lat = 3;
      apply_reset(1'b0);
      n = 0; n_inc = 0;
      for (int c = 0; c < 80 && n < 4; c++) begin
         if (c > 0) step();
         if (bus.incPC) n_inc++;
         if (bus.inst_valid && bus.inst_ready) begin
            got_inst[n] = bus.inst;
            got_addr[n] = bus.inst_addr;
            n++;
         end
      end
      bus.halt = 1'b1;
      repeat (6) begin step(); if (bus.incPC) n_inc++; end
      chk("s1_words_seen", 32'(n), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("s1_inst%0d", k),      got_inst[k],      32'h0000_00A0 + 32'(k));
         chk($sformatf("s1_inst_addr%0d", k), 32'(got_addr[k]), 32'(k));
      end
      chk("s1_incPC_pulses", 32'(n_inc), 32'd4);

      // Decoder stalls five cycles on a held word
      lat = 1;
      apply_reset(1'b0);
      bus.inst_ready = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) step();
         if (bus.inst_valid) begin found = 1'b1; break; end
      end
      chk("s2_held_seen", 32'(found), 32'h1);
      v0 = bus.inst;
      chk("s2_inst", v0, 32'hA0);
      bad = 0; n_inc = 0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) step();
         if (bus.incPC) n_inc++;
         if (bus.inst !== v0 || bus.inst_valid !== 1'b1 || bus.mem_req !== 1'b0) bad++;
      end
      chk("s2_hold_stable", 32'(bad), 32'h0);
      chk("s2_incPC_once", 32'(n_inc), 32'd1);
      bus.inst_ready = 1'b1;

      // Branch while waiting on a slow read: the stale word must be drained
      lat = 4;
      apply_reset(1'b0);
      step();
      bus.branch_taken = 1'b1;
      bus.branch_target = 16'h40;
      step();
      bus.branch_taken = 1'b0;
      chk("s3_loadFromI", 32'(bus.loadFromI), 32'h1);
      chk("s3_I", 32'(bus.I), 32'h40);
      lf = 0; early = 0; found = 1'b0; got_req = 1'b0; req_a = 16'hFFFF;
      for (int c = 0; c < 30; c++) begin
         step();
         if (bus.loadFromI) lf++;
         if (bus.mem_req && !got_req) begin got_req = 1'b1; req_a = bus.mem_addr; end
         if (bus.inst_valid) begin found = 1'b1; break; end
         if (bus.incPC) early++;
      end
      chk("s3_loadFromI_extra", 32'(lf), 32'h0);
      chk("s3_next_mem_addr", 32'(req_a), 32'h40);
      chk("s3_found", 32'(found), 32'h1);
      chk("s3_inst", bus.inst, 32'hE0);
      chk("s3_inst_addr", 32'(bus.inst_addr), 32'h40);
      chk("s3_incPC_early", 32'(early), 32'h0);

      // Branch in the same cycle the read returns
      lat = 2;
      apply_reset(1'b0);
      rv = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) step();
         if (bus.mem_rvalid) begin rv = 1'b1; break; end
      end
      chk("s4_rvalid_seen", 32'(rv), 32'h1);
      bus.branch_taken = 1'b1;
      bus.branch_target = 16'h20;
      step();
      bus.branch_taken = 1'b0;
      chk("s4_incPC", 32'(bus.incPC), 32'h0);
      chk("s4_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("s4_loadFromI", 32'(bus.loadFromI), 32'h1);
      chk("s4_I", 32'(bus.I), 32'h20);
      lat = 4;
      step();
      chk("s4_mem_req", 32'(bus.mem_req), 32'h1);
      chk("s4_mem_addr", 32'(bus.mem_addr), 32'h20);

      // Reset while waiting on memory; the late response must be ignored
      step();
      reset = 1'b1;
      bus.halt = 1'b1;
      #1;
      chk("s5_incPC", 32'(bus.incPC), 32'h0);
      chk("s5_loadFromI", 32'(bus.loadFromI), 32'h0);
      chk("s5_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("s5_I", 32'(bus.I), 32'h0);
      chk("s5_inst", bus.inst, 32'h0);
      chk("s5_inst_addr", 32'(bus.inst_addr), 32'h0);
      chk("s5_mem_req", 32'(bus.mem_req), 32'h0);
      step();
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (bus.inst_valid || bus.incPC || bus.mem_req || bus.loadFromI) bad++;
      end
      chk("s5_stale_ignored", 32'(bad), 32'h0);
      @(negedge clk);
      bus.halt = 1'b0;
      #1;
      chk("s5_release_req", 32'(bus.mem_req), 32'h1);
      chk("s5_release_addr", 32'(bus.mem_addr), 32'h0);

      chk("incPC_loadFromI_exclusive", 32'(n_excl), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
